// File: rtl/ri5cy_lsu_pkg.sv
// Shared encodings for the writeback load/store unit: load funct3 and store
// type codes (including the "no access" markers), the FSM state type, the
// datapath width, and the alignment check used by the optional trap build.
package ri5cy_lsu_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [2:0] LOAD_LB   = 3'b000;
    localparam logic [2:0] LOAD_LH   = 3'b001;
    localparam logic [2:0] LOAD_LW   = 3'b010;
    localparam logic [2:0] LOAD_LBU  = 3'b100;
    localparam logic [2:0] LOAD_LHU  = 3'b101;
    localparam logic [2:0] LOAD_NONE = 3'b111;

    localparam logic [1:0] STORE_SB   = 2'b00;
    localparam logic [1:0] STORE_SH   = 2'b01;
    localparam logic [1:0] STORE_SW   = 2'b10;
    localparam logic [1:0] STORE_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // True when the access cannot be served by a single aligned word access.
    // A pending load wins over a store, matching the unit's priority rule.
    function automatic logic lsu_misaligned(input logic [2:0] load_type,
                                            input logic [1:0] store_type,
                                            input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (load_type != LOAD_NONE) begin
            if (load_type == LOAD_LH || load_type == LOAD_LHU)
                mis = off[0];
            else if (load_type == LOAD_LW)
                mis = (off != 2'b00);
        end else begin
            if (store_type == STORE_SH)
                mis = off[0];
            else if (store_type == STORE_SW)
                mis = (off != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: selects the addressed byte/halfword lane of the read
// word and sign- or zero-extends it; words pass through unchanged.
// Purely combinational, no state.
module lsu_load_ext
    import ri5cy_lsu_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] rdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            load_type,
    output logic [WORD_WIDTH-1:0] ext
);

    logic [WORD_WIDTH-1:0] byte_sh;
    logic [WORD_WIDTH-1:0] half_sh;

    // Shift the addressed lane down to bit 0, then extend by load type.
    always_comb begin
        byte_sh = rdata >> {offset, 3'b000};
        half_sh = rdata >> {offset[1], 4'b0000};
        case (load_type)
            LOAD_LB:  ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
            LOAD_LBU: ext = {24'h0, byte_sh[7:0]};
            LOAD_LH:  ext = {{16{half_sh[15]}}, half_sh[15:0]};
            LOAD_LHU: ext = {16'h0, half_sh[15:0]};
            default:  ext = rdata;
        endcase
    end

endmodule

// File: rtl/wb_lsu.sv
// Writeback-stage load/store unit: ALU results write back combinationally,
// loads/stores run a req/gnt/rvalid transaction while stalling the pipeline.
// Optional build macro RI5CY_LSU_MISALIGN_TRAP_EN: misaligned half/word
// accesses are not issued and raise a one-cycle misaligned_o pulse instead.
module wb_lsu #(
    parameter int WORD_WIDTH = ri5cy_lsu_pkg::WORD_WIDTH  // only 32 supported
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            load_type_i,
    input  logic [1:0]            store_type_i,
    input  logic                  write_en_i,
    input  logic [4:0]            rd_addr_i,
    input  logic [WORD_WIDTH-1:0] ex_data_i,
    input  logic [WORD_WIDTH-1:0] store_data_i,
    output logic                  stall_ctrl_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [WORD_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [WORD_WIDTH-1:0] data_wdata_o,
    input  logic [WORD_WIDTH-1:0] data_rdata_i,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [WORD_WIDTH-1:0] rf_wdata_o,
    output logic                  misaligned_o
);

    import ri5cy_lsu_pkg::*;

    lsu_state_e state, state_nxt;

    logic [1:0]            off;
    logic                  is_load;
    logic                  is_store;
    logic                  mis;
    logic                  mem_op;
    logic                  done;
    logic [3:0]            lane_be;
    logic [WORD_WIDTH-1:0] lane_wdata;
    logic [WORD_WIDTH-1:0] ext_data;

    assign off      = ex_data_i[1:0];
    assign is_load  = (load_type_i != LOAD_NONE);
    assign is_store = !is_load && (store_type_i != STORE_NONE);

`ifdef RI5CY_LSU_MISALIGN_TRAP_EN
    assign mis = lsu_misaligned(load_type_i, store_type_i, off);
`else
    // Misaligned half/word accesses are simply truncated to alignment.
    assign mis = 1'b0;
`endif

    // A trapped access never reaches the memory side.
    assign mem_op = (is_load || is_store) && !mis;
    assign done   = (state == RESP) && data_rvalid_i;

    lsu_load_ext u_load_ext (
        .rdata     (data_rdata_i),
        .offset    (off),
        .load_type (load_type_i),
        .ext       (ext_data)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: issue in IDLE, wait for gnt in REQ, wait for rvalid in RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op) state_nxt = data_gnt_i ? RESP : REQ;
            REQ:     if (data_gnt_i) state_nxt = RESP;
            RESP:    if (data_rvalid_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte enables and lane-replicated store data; loads use the same lane
    // mask by access size so the memory sees which bytes are wanted.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = '0;
        if (is_load) begin
            if (load_type_i == LOAD_LB || load_type_i == LOAD_LBU)
                lane_be = 4'b0001 << off;
            else if (load_type_i == LOAD_LH || load_type_i == LOAD_LHU)
                lane_be = 4'b0011 << {off[1], 1'b0};
        end else begin
            case (store_type_i)
                STORE_SB: begin
                    lane_be    = 4'b0001 << off;
                    lane_wdata = {4{store_data_i[7:0]}};
                end
                STORE_SH: begin
                    lane_be    = 4'b0011 << {off[1], 1'b0};
                    lane_wdata = {2{store_data_i[15:0]}};
                end
                default: begin
                    lane_be    = 4'b1111;
                    lane_wdata = store_data_i;
                end
            endcase
        end
    end

    // Outputs; everything is forced low while rst is held.
    always_comb begin
        stall_ctrl_o = 1'b0;
        data_req_o   = 1'b0;
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_wdata_o = '0;
        rf_we_o      = 1'b0;
        rf_waddr_o   = 5'd0;
        rf_wdata_o   = '0;
        misaligned_o = 1'b0;
        if (!rst) begin
            stall_ctrl_o = mem_op && !done;
            data_req_o   = mem_op && (state != RESP);
            if (mem_op) begin
                data_addr_o  = {ex_data_i[WORD_WIDTH-1:2], 2'b00};
                data_we_o    = is_store;
                data_be_o    = lane_be;
                data_wdata_o = lane_wdata;
            end
            rf_waddr_o = rd_addr_i;
            if (!is_load && !is_store) begin
                rf_we_o    = write_en_i;
                rf_wdata_o = ex_data_i;
            end else if (done && is_load) begin
                rf_we_o    = write_en_i;
                rf_wdata_o = ext_data;
            end
            misaligned_o = mis;
        end
    end

endmodule

// File: tb/tb_wb_lsu.sv
// Self-checking bench for wb_lsu: expected memory requests and register-file
// writebacks are queued when an op is driven and compared by a monitor.
// Build with or without RI5CY_LSU_MISALIGN_TRAP_EN; expectations follow it.
module tb_wb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  load_type_i;
    logic [1:0]  store_type_i;
    logic        write_en_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] ex_data_i;
    logic [31:0] store_data_i;
    logic        stall_ctrl_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        misaligned_o;

    wb_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .load_type_i   (load_type_i),
        .store_type_i  (store_type_i),
        .write_en_i    (write_en_i),
        .rd_addr_i     (rd_addr_i),
        .ex_data_i     (ex_data_i),
        .store_data_i  (store_data_i),
        .stall_ctrl_o  (stall_ctrl_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_t;

    req_t req_q[$];
    rf_t  rf_q[$];
    req_t re;
    rf_t  fe;
    logic op_live = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: requests are compared every cycle they are up (so a held
    // request must stay stable) and retired on gnt; writeback is compared
    // on the cycle the op leaves the stage.
    always @(negedge clk) begin
        if (data_req_o) begin
            if (req_q.size() == 0) begin
                check("req_unexpected", 1, 0);
            end else begin
                re = req_q[0];
                check("req_addr", data_addr_o, re.addr);
                check("req_we", data_we_o, re.we);
                if (re.we) begin
                    check("req_be", data_be_o, re.be);
                    check("req_wdata", data_wdata_o, re.wdata);
                end
                if (data_gnt_i) void'(req_q.pop_front());
            end
        end
        if (op_live && !stall_ctrl_o) begin
            if (rf_q.size() == 0) begin
                check("rf_unexpected", 1, 0);
            end else begin
                fe = rf_q.pop_front();
                check("rf_we", rf_we_o, fe.we);
                check("rf_waddr", rf_waddr_o, fe.waddr);
                if (fe.we) check("rf_wdata", rf_wdata_o, fe.wdata);
            end
        end
    end

    task automatic idle_inputs();
        load_type_i   = 3'b111;
        store_type_i  = 2'b11;
        write_en_i    = 1'b0;
        rd_addr_i     = 5'd0;
        ex_data_i     = 32'h0;
        store_data_i  = 32'h0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
    endtask

    // Present one op (called at posedge+1) and play the memory side with the
    // given gnt/rvalid wait cycles. rvalid is also raised spuriously before
    // the grant, which the unit must ignore.
    task automatic run_op(input string tag, input logic [2:0] lt, input logic [1:0] st,
                          input logic we, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] sd, input int gnt_wait, input int rv_wait,
                          input logic [31:0] rdata, input logic exp_req,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic exp_rf_we,
                          input logic [31:0] exp_rf_wdata, input logic exp_mis,
                          input int exp_stall);
        int   g = 0;
        int   r = 0;
        int   stalls = 0;
        bit   granted = 0;
        bit   done = 0;
        logic is_st;
        is_st        = (lt == 3'b111) && (st != 2'b11);
        load_type_i  = lt;
        store_type_i = st;
        write_en_i   = we;
        rd_addr_i    = rd;
        ex_data_i    = addr;
        store_data_i = sd;
        op_live      = 1'b1;
        if (exp_req) req_q.push_back('{exp_addr, exp_be, is_st, exp_wdata});
        rf_q.push_back('{exp_rf_we, rd, exp_rf_wdata});
        for (int c = 0; c < 64 && !done; c++) begin
            data_gnt_i    = !granted && (g >= gnt_wait);
            data_rvalid_i = granted ? (r >= rv_wait) : 1'b1;
            data_rdata_i  = (granted && r >= rv_wait) ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            if (c == 0) begin
                check({tag, "_mis"}, misaligned_o, exp_mis);
                check({tag, "_req0"}, data_req_o, exp_req);
            end
            if (stall_ctrl_o) stalls++;
            else done = 1;
            if (granted) r++;
            else if (data_req_o && data_gnt_i) granted = 1;
            else if (data_req_o) g++;
            @(posedge clk);
            #1;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
        check({tag, "_stalls"}, stalls, exp_stall);
        op_live = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        // Reset with an ALU write and then a load presented: all outputs low.
        load_type_i = 3'b111; write_en_i = 1'b1; rd_addr_i = 5'd5; ex_data_i = 32'h1234_5678;
        data_gnt_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs_alu", |{stall_ctrl_o, data_req_o, data_addr_o, data_we_o, data_be_o,
              data_wdata_o, rf_we_o, rf_waddr_o, rf_wdata_o, misaligned_o}, 0);
        load_type_i = 3'b010;
        #1;
        check("rst_outs_ld", |{stall_ctrl_o, data_req_o, data_addr_o, data_we_o, data_be_o,
              data_wdata_o, rf_we_o, rf_waddr_o, rf_wdata_o, misaligned_o}, 0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU writeback, gnt floating high with no request.
        run_op("alu", 3'b111, 2'b11, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 0, 0, 32'h0,
               1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 0);
        // SB to byte 3.
        run_op("sb", 3'b111, 2'b00, 1'b1, 5'd1, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 32'h0,
               1'b1, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 1'b0, 32'h0, 1'b0, 1);
        // LB with a 3-cycle grant delay, then LBU on the same data.
        run_op("lb", 3'b000, 2'b11, 1'b1, 5'd7, 32'h0000_2001, 32'h0, 3, 0, 32'h0000_8000,
               1'b1, 32'h0000_2000, 4'b0010, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 4);
        run_op("lbu", 3'b100, 2'b11, 1'b1, 5'd8, 32'h0000_2001, 32'h0, 0, 2, 32'h0000_8000,
               1'b1, 32'h0000_2000, 4'b0010, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 3);
        // LH upper half, then back-to-back LW.
        run_op("lh", 3'b001, 2'b11, 1'b1, 5'd9, 32'h0000_2002, 32'h0, 1, 1, 32'h7FFF_0000,
               1'b1, 32'h0000_2000, 4'b1100, 32'h0, 1'b1, 32'h0000_7FFF, 1'b0, 3);
        run_op("lw_b2b", 3'b010, 2'b11, 1'b1, 5'd10, 32'h0000_3000, 32'h0, 0, 0, 32'hCAFE_F00D,
               1'b1, 32'h0000_3000, 4'b1111, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1);
        // Halfword/word stores, lower-half loads, top-byte load.
        run_op("sh", 3'b111, 2'b01, 1'b0, 5'd0, 32'h0000_2006, 32'h1234_ABCD, 0, 1, 32'h0,
               1'b1, 32'h0000_2004, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0, 1'b0, 2);
        run_op("sw", 3'b111, 2'b10, 1'b0, 5'd0, 32'h0000_2008, 32'h1122_3344, 2, 0, 32'h0,
               1'b1, 32'h0000_2008, 4'b1111, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 3);
        run_op("lhu", 3'b101, 2'b11, 1'b1, 5'd11, 32'h0000_2000, 32'h0, 0, 0, 32'h1234_F00F,
               1'b1, 32'h0000_2000, 4'b0011, 32'h0, 1'b1, 32'h0000_F00F, 1'b0, 1);
        run_op("lh_neg", 3'b001, 2'b11, 1'b1, 5'd12, 32'h0000_2000, 32'h0, 0, 0, 32'h1234_F00F,
               1'b1, 32'h0000_2000, 4'b0011, 32'h0, 1'b1, 32'hFFFF_F00F, 1'b0, 1);
        run_op("lb3", 3'b000, 2'b11, 1'b1, 5'd13, 32'h0000_1003, 32'h0, 0, 0, 32'h7F00_0000,
               1'b1, 32'h0000_1000, 4'b1000, 32'h0, 1'b1, 32'h0000_007F, 1'b0, 1);

        // Reset while waiting in RESP abandons the load.
        load_type_i = 3'b010; write_en_i = 1'b1; rd_addr_i = 5'd3; ex_data_i = 32'h0000_5000;
        data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
        req_q.push_back('{32'h0000_5000, 4'b1111, 1'b0, 32'h0});
        @(posedge clk);
        #1;
        data_gnt_i = 1'b0;
        @(negedge clk);
        check("resp_stall", stall_ctrl_o, 1);
        check("resp_noreq", data_req_o, 0);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_outs", |{stall_ctrl_o, data_req_o, data_addr_o, data_we_o, data_be_o,
              data_wdata_o, rf_we_o, rf_waddr_o, rf_wdata_o, misaligned_o}, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        run_op("lw_after_rst", 3'b010, 2'b11, 1'b1, 5'd4, 32'h0000_3004, 32'h0, 0, 0, 32'h0BAD_F00D,
               1'b1, 32'h0000_3004, 4'b1111, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 1);

        // Misaligned word load.
`ifdef RI5CY_LSU_MISALIGN_TRAP_EN
        run_op("lw_mis", 3'b010, 2'b11, 1'b1, 5'd14, 32'h0000_4002, 32'h0, 0, 0, 32'h89AB_CDEF,
               1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 0);
        run_op("sh_mis", 3'b111, 2'b01, 1'b0, 5'd0, 32'h0000_4001, 32'h5555_6666, 0, 0, 32'h0,
               1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 0);
`else
        run_op("lw_mis", 3'b010, 2'b11, 1'b1, 5'd14, 32'h0000_4002, 32'h0, 0, 0, 32'h89AB_CDEF,
               1'b1, 32'h0000_4000, 4'b1111, 32'h0, 1'b1, 32'h89AB_CDEF, 1'b0, 1);
        run_op("sh_mis", 3'b111, 2'b01, 1'b0, 5'd0, 32'h0000_4001, 32'h5555_6666, 0, 0, 32'h0,
               1'b1, 32'h0000_4000, 4'b0011, 32'h6666_6666, 1'b0, 32'h0, 1'b0, 1);
`endif

        repeat (2) @(posedge clk);
        check("req_q_drained", req_q.size(), 0);
        check("rf_q_drained", rf_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
